// File: rtl/serial_paralelo_align_if.sv
// Lane receiver bus: serial bit input plus parallel word and link status outputs.
interface serial_paralelo_align_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LOCK_COUNT = 4
);
  localparam int unsigned CW = $clog2(LOCK_COUNT + 1);

  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             idle_out;
  logic             active;
  logic [CW-1:0]    comma_cnt;

  modport master (
    output data_in,
    input  data_out, valid_out, idle_out, active, comma_cnt
  );

  modport slave (
    input  data_in,
    output data_out, valid_out, idle_out, active, comma_cnt
  );
endinterface

// File: rtl/serial_paralelo_align.sv
// Serial-to-parallel lane receiver with comma-based word alignment, idle
// suppression and loss-of-lock detection. One bit per clk_32f, MSB first.
module serial_paralelo_align #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
  parameter logic [WIDTH-1:0] IDLE       = 8'h7C,
  parameter int unsigned      LOCK_COUNT = 4,
  parameter int unsigned      LOSS_COUNT = 2
) (
  input logic                clk_32f,
  input logic                reset,
  serial_paralelo_align_if.slave bus
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned LW = $clog2(LOSS_COUNT + 1);

  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_COUNT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_COUNT - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t state, state_next;

  // The oldest bit of a word is never needed again once nxt is formed,
  // so only WIDTH-1 history bits are kept.
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] nxt;
  logic [BW-1:0]    bitc, bitc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    loss_q, loss_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             idle_q, idle_d;
  logic             boundary;
  logic             is_comma;
  logic             is_idle;

  assign nxt      = {sr, bus.data_in};
  assign boundary = (bitc == LAST_BIT);
  assign is_comma = (nxt == COMMA);
  assign is_idle  = (nxt == IDLE);

  // State register; reset drops the link immediately.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) state <= SEARCH;
    else       state <= state_next;
  end

  // Next-state: hunt for any comma, confirm on boundaries, fall out on repeated misplaced commas.
  always_comb begin
    state_next = state;
    unique case (state)
      SEARCH: begin
        if (is_comma) begin
          if (LOCK_COUNT == 1) state_next = LOCKED;
          else                 state_next = ALIGN;
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (!is_comma)               state_next = SEARCH;
          else if (cnt_q == LOCK_LAST) state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (!boundary && is_comma && (loss_q == LOSS_LAST)) state_next = SEARCH;
      end
      default: state_next = SEARCH;
    endcase
  end

  // Output/datapath next values: bit phase, comma and loss counters, word capture and strobes.
  always_comb begin
    bitc_d  = boundary ? '0 : bitc + 1'b1;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    data_d  = data_q;
    valid_d = 1'b0;
    idle_d  = 1'b0;
    unique case (state)
      SEARCH: begin
        cnt_d  = '0;
        loss_d = '0;
        if (is_comma) begin
          bitc_d = '0;
          cnt_d  = CNT_ONE;
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (is_comma) cnt_d = cnt_q + 1'b1;
          else          cnt_d = '0;
        end
      end
      LOCKED: begin
        if (boundary) begin
          if (is_comma) loss_d = '0;
          if (is_idle) begin
            idle_d = 1'b1;
          end else begin
            data_d  = nxt;
            valid_d = 1'b1;
          end
        end else if (is_comma) begin
          if (loss_q == LOSS_LAST) begin
            loss_d = '0;
            cnt_d  = '0;
          end else begin
            loss_d = loss_q + 1'b1;
          end
        end
      end
      default: begin
        cnt_d  = '0;
        loss_d = '0;
      end
    endcase
  end

  // Datapath registers; an asserted reset discards any partially received word.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      sr      <= '0;
      bitc    <= '0;
      cnt_q   <= '0;
      loss_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      idle_q  <= 1'b0;
    end else begin
      sr      <= nxt[WIDTH-2:0];
      bitc    <= bitc_d;
      cnt_q   <= cnt_d;
      loss_q  <= loss_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      idle_q  <= idle_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.idle_out  = idle_q;
  assign bus.active    = (state == LOCKED);
  assign bus.comma_cnt = cnt_q;

endmodule

// File: tb/tb_serial_paralelo_align.sv
// Bench for serial_paralelo_align: an 8-bit default build and a 10-bit build,
// each compared every bit against a word-level reference model.
module tb_serial_paralelo_align;

  localparam logic [7:0] COMMA8  = 8'hBC;
  localparam logic [7:0] IDLE8   = 8'h7C;
  localparam logic [9:0] COMMA10 = 10'h17C;

  localparam int HUNT  = 0;
  localparam int TRAIN = 1;
  localparam int RUN   = 2;

  logic clk_32f = 1'b0;
  logic reset8  = 1'b1;
  logic reset10 = 1'b1;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int strobe_valid = 0;
  int strobe_idle  = 0;

  int m_hist[2];
  int m_age[2];
  int m_mode[2];
  int m_commas[2];
  int m_losses[2];
  int m_data[2];
  bit m_valid[2];
  bit m_idle[2];

  always #5 clk_32f = ~clk_32f;

  serial_paralelo_align_if #(.WIDTH(8),  .LOCK_COUNT(4)) bus8 ();
  serial_paralelo_align_if #(.WIDTH(10), .LOCK_COUNT(2)) bus10 ();

  serial_paralelo_align dut8 (
    .clk_32f (clk_32f),
    .reset   (reset8),
    .bus     (bus8)
  );

  serial_paralelo_align #(
    .WIDTH(10), .COMMA(10'h17C), .IDLE(10'h283), .LOCK_COUNT(2), .LOSS_COUNT(2)
  ) dut10 (
    .clk_32f (clk_32f),
    .reset   (reset10),
    .bus     (bus10)
  );

  function automatic int width_of(input int k);
    return (k == 0) ? 8 : 10;
  endfunction

  function automatic int comma_of(input int k);
    return (k == 0) ? 32'hBC : 32'h17C;
  endfunction

  function automatic int idle_of(input int k);
    return (k == 0) ? 32'h7C : 32'h283;
  endfunction

  function automatic int lock_of(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  task automatic model_reset(input int k);
    m_hist[k] = 0; m_age[k] = 0; m_mode[k] = HUNT; m_commas[k] = 0;
    m_losses[k] = 0; m_data[k] = 0; m_valid[k] = 0; m_idle[k] = 0;
  endtask

  // Reference: the last W received bits form a word; words land every W bits after the last realign.
  task automatic model_step(input int k, input bit b);
    int  w;
    int  word;
    bit  on_word;
    w           = width_of(k);
    word        = ((m_hist[k] << 1) | int'(b)) & ((1 << w) - 1);
    m_hist[k]   = word;
    m_age[k]    = m_age[k] + 1;
    on_word     = (m_age[k] % w) == 0;
    m_valid[k]  = 0;
    m_idle[k]   = 0;
    if (m_mode[k] == HUNT) begin
      m_commas[k] = 0;
      if (word == comma_of(k)) begin
        m_age[k]    = 0;
        m_commas[k] = 1;
        m_mode[k]   = (lock_of(k) == 1) ? RUN : TRAIN;
      end
    end else if (m_mode[k] == TRAIN) begin
      if (on_word) begin
        if (word == comma_of(k)) begin
          m_commas[k] = m_commas[k] + 1;
          if (m_commas[k] == lock_of(k)) m_mode[k] = RUN;
        end else begin
          m_commas[k] = 0;
          m_mode[k]   = HUNT;
        end
      end
    end else begin
      if (on_word) begin
        if (word == comma_of(k)) m_losses[k] = 0;
        if (word == idle_of(k)) m_idle[k] = 1;
        else begin
          m_data[k]  = word;
          m_valid[k] = 1;
        end
      end else if (word == comma_of(k)) begin
        m_losses[k] = m_losses[k] + 1;
        if (m_losses[k] == 2) begin
          m_mode[k] = HUNT; m_commas[k] = 0; m_losses[k] = 0;
        end
      end
    end
  endtask

  task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_output(input int k, input string tag);
    logic [15:0] d, c;
    logic        v, i, a;
    if (k == 0) begin
      d = 16'(bus8.data_out);  c = 16'(bus8.comma_cnt);
      v = bus8.valid_out;      i = bus8.idle_out;   a = bus8.active;
    end else begin
      d = 16'(bus10.data_out); c = 16'(bus10.comma_cnt);
      v = bus10.valid_out;     i = bus10.idle_out;  a = bus10.active;
    end
    if (v) strobe_valid++;
    if (i) strobe_idle++;
    check_value({tag, "/data_out"},  d, 16'(m_data[k]));
    check_value({tag, "/valid_out"}, 16'(v), 16'(m_valid[k]));
    check_value({tag, "/idle_out"},  16'(i), 16'(m_idle[k]));
    check_value({tag, "/active"},    16'(a), 16'(m_mode[k] == RUN));
    check_value({tag, "/comma_cnt"}, c, 16'(m_commas[k]));
  endtask

  task automatic apply_stimulus(input int k, input bit b, input string tag);
    if (k == 0) bus8.data_in = b;
    else        bus10.data_in = b;
    @(posedge clk_32f);
    model_step(k, b);
    #1;
    check_output(k, tag);
  endtask

  task automatic send_word(input int k, input int w, input string tag);
    for (int i = width_of(k) - 1; i >= 0; i--) apply_stimulus(k, w[i], tag);
  endtask

  task automatic do_reset(input int k);
    if (k == 0) reset8 = 1'b1; else reset10 = 1'b1;
    repeat (2) @(posedge clk_32f);
    #1;
    if (k == 0) reset8 = 1'b0; else reset10 = 1'b0;
    model_reset(k);
    check_output(k, "reset");
  endtask

  initial begin
    int w;
    bus8.data_in  = 1'b0;
    bus10.data_in = 1'b0;
    #1;

    // Reset values of the 8-bit build
    do_reset(0);
    check_value("reset_active", 16'(bus8.active), 16'h0);

    // Four commas lock, then three idles pulse idle_out only
    for (int i = 0; i < 4; i++) begin
      send_word(0, COMMA8, "lock");
      check_value("lock_cnt", 16'(bus8.comma_cnt), 16'(i + 1));
      check_value("lock_active", 16'(bus8.active), 16'(i == 3));
    end
    strobe_valid = 0; strobe_idle = 0;
    for (int i = 0; i < 3; i++) send_word(0, IDLE8, "idle");
    check_value("idle_pulses", 16'(strobe_idle), 16'd3);
    check_value("idle_no_valid", 16'(strobe_valid), 16'd0);
    check_value("idle_data", 16'(bus8.data_out), 16'h0);

    // Broken lock: a non-comma on a boundary restarts the search
    do_reset(0);
    for (int i = 0; i < 3; i++) send_word(0, COMMA8, "broken_a");
    send_word(0, 8'hA5, "broken_a5");
    check_value("broken_cnt", 16'(bus8.comma_cnt), 16'h0);
    check_value("broken_active", 16'(bus8.active), 16'h0);
    for (int i = 0; i < 4; i++) send_word(0, COMMA8, "broken_b");
    check_value("broken_relock", 16'(bus8.active), 16'h1);

    // Misaligned start, then one data word and random traffic
    do_reset(0);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 1'($urandom_range(0, 1)), "offset");
    for (int i = 0; i < 4; i++) send_word(0, COMMA8, "mis_lock");
    strobe_valid = 0;
    send_word(0, 8'h3C, "mis_data");
    check_value("mis_data_out", 16'(bus8.data_out), 16'h3C);
    check_value("mis_valid", 16'(bus8.valid_out), 16'h1);
    check_value("mis_pulses", 16'(strobe_valid), 16'd1);
    for (int n = 0; n < 10; n++) send_word(0, int'($urandom_range(0, 255)), "rand8");

    // Loss of lock: two off-boundary commas drop the link
    do_reset(0);
    for (int i = 0; i < 4; i++) send_word(0, COMMA8, "loss_lock");
    apply_stimulus(0, 1'b1, "loss_pre");
    apply_stimulus(0, 1'b0, "loss_pre");
    send_word(0, COMMA8, "loss_1");
    check_value("loss_first", 16'(bus8.active), 16'h1);
    send_word(0, COMMA8, "loss_2");
    check_value("loss_second", 16'(bus8.active), 16'h0);
    check_value("loss_cnt", 16'(bus8.comma_cnt), 16'h0);
    for (int i = 0; i < 4; i++) begin
      send_word(0, COMMA8, "loss_relock");
      check_value("loss_relock_active", 16'(bus8.active), 16'(i == 3));
    end
    for (int n = 0; n < 6; n++) send_word(0, int'($urandom_range(0, 255)), "rand8b");

    // 10-bit build: two commas lock, one data word follows
    do_reset(1);
    for (int i = 0; i < 2; i++) send_word(1, COMMA10, "w10_lock");
    check_value("w10_active", 16'(bus10.active), 16'h1);
    check_value("w10_cnt", 16'(bus10.comma_cnt), 16'd2);
    w = int'($urandom_range(0, 1023));
    while (w == 32'h17C || w == 32'h283) w = int'($urandom_range(0, 1023));
    strobe_valid = 0;
    send_word(1, w, "w10_data");
    check_value("w10_data_out", 16'(bus10.data_out), 16'(w));
    check_value("w10_pulses", 16'(strobe_valid), 16'd1);

    // Reset between two bits of a partial word
    w = int'($urandom_range(0, 1023));
    for (int i = 9; i >= 6; i--) apply_stimulus(1, w[i], "w10_partial");
    #2;
    reset10 = 1'b1;
    #1;
    check_value("async_active", 16'(bus10.active), 16'h0);
    check_value("async_valid", 16'(bus10.valid_out), 16'h0);
    check_value("async_data", 16'(bus10.data_out), 16'h0);
    @(posedge clk_32f);
    #1;
    reset10 = 1'b0;
    model_reset(1);
    strobe_valid = 0; strobe_idle = 0;
    for (int i = 5; i >= 0; i--) apply_stimulus(1, w[i], "w10_after");
    check_value("w10_no_strobe", 16'(strobe_valid + strobe_idle), 16'd0);
    for (int i = 0; i < 2; i++) send_word(1, COMMA10, "w10_relock");
    for (int n = 0; n < 4; n++) send_word(1, int'($urandom_range(0, 1023)), "rand10");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_align.md
Name: serial_paralelo_align

Overview:
Parametrised serial-to-parallel receiver with comma-based word alignment for the PHY lane. It consumes one bit per clk_32f cycle, MSB first, and searches bit-by-bit for the COMMA pattern. Once LOCK_COUNT consecutive commas arrive on word boundaries, it declares the link active and emits WIDTH-bit words with a one-cycle valid strobe. IDLE words are flagged and suppressed. It generalises the fixed 8-bit $BC/$7C converter to any word width, comma, idle code and lock depth, and adds loss-of-lock detection.

Parameters:
WIDTH, 8, word width in bits (minimum 4)
COMMA, 8'hBC, alignment pattern (WIDTH bits)
IDLE, 8'h7C, idle pattern (WIDTH bits); never emitted as data
LOCK_COUNT, 4, consecutive on-boundary commas required to reach LOCKED (minimum 1)
LOSS_COUNT, 2, consecutive off-boundary comma detections in LOCKED that force a return to SEARCH (minimum 1)

Ports:
clk_32f  input  1  bit clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  1  serial data, MSB of each word first
data_out  output  WIDTH  last parallel word accepted
valid_out  output  1  one-cycle strobe: data_out holds a new non-IDLE word
idle_out  output  1  one-cycle strobe: the word just completed equals IDLE (LOCKED only)
active  output  1  high while the block is in LOCKED
comma_cnt  output  $clog2(LOCK_COUNT+1)  consecutive on-boundary commas counted during ALIGN

Behaviour:
- Reset (asynchronous): shift register, data_out, bit counter, comma_cnt and loss counter = 0; valid_out = idle_out = active = 0; state = SEARCH. If reset asserts mid-word or in LOCKED, all outputs clear immediately and no partial word is emitted.
- Shift register: sr <= {sr[WIDTH-2:0], data_in} every cycle. Define nxt = {sr[WIDTH-2:0], data_in}, the word that ends with the bit sampled at this edge.
- Bit counter: bitc counts 0..WIDTH-1. A word boundary is the edge at which bitc == WIDTH-1; bitc then wraps to 0.
- SEARCH: bitc is ignored. On any edge with nxt == COMMA: bitc <= 0 (boundary realigned), comma_cnt <= 1, and state <= ALIGN. If LOCK_COUNT == 1, state goes directly to LOCKED instead.
- ALIGN: at each boundary:
  - if nxt == COMMA: comma_cnt increments; when it reaches LOCK_COUNT, state <= LOCKED and active <= 1 on that same edge.
  - otherwise: comma_cnt <= 0 and state <= SEARCH.
  - Between boundaries, nxt is not compared.
- LOCKED: at each boundary:
  - data_out <= nxt unless nxt == IDLE.
  - valid_out = 1 for the following cycle if nxt != IDLE. A comma on the boundary is emitted as valid data.
  - idle_out = 1 for the following cycle if nxt == IDLE; data_out holds its previous value.
  - Between boundaries, valid_out and idle_out = 0.
- Loss of lock: in LOCKED, on a non-boundary edge with nxt == COMMA, the loss counter increments. An on-boundary COMMA clears it. Reaching LOSS_COUNT forces: state <= SEARCH, active <= 0, comma_cnt <= 0, and no strobe. The realign rule then applies from the next comma.
- Latency: valid_out rises exactly one cycle after the edge sampling the word's last bit.
- Throughput: at most one strobe per WIDTH cycles.
- comma_cnt holds its value in LOCKED and clears in SEARCH.

Test Plan:
- Reset: hold reset high 2 cycles, release -> data_out=0, valid_out=0, idle_out=0, active=0, comma_cnt=0.
- Lock then idle: 4x 8'hBC then 3x 8'h7C, MSB first -> comma_cnt steps 1,2,3; active rises on the edge sampling the last bit of the 4th BC; then 3 idle_out pulses 8 cycles apart, valid_out never high, data_out=0.
- Broken lock sequence: 3x BC, 1x 8'hA5, then 4x BC -> after A5, state returns to SEARCH and comma_cnt=0; lock is reached only after the second group; active=1.
- Misaligned start: 3 random bits, then 4x BC, then 8'h3C -> alignment is found regardless of offset; data_out=8'h3C with one valid_out pulse, 8 cycles after the last BC boundary.
- Loss of lock: from LOCKED, inject bit stream 1,0,1,0,1,1,1,1,0,0,... so that BC appears off-boundary twice -> active drops on the 2nd detection; relock requires 4 fresh commas.
- Reset mid-lock / WIDTH=10 build (COMMA=10'h17C, IDLE=10'h283, LOCK_COUNT=2):
  - asserting reset between two bits clears active asynchronously, and no strobe appears for the partial word;
  - 2 commas lock the 10-bit build, and a following data word appears on data_out with valid_out.
